spi_ram_ctrl: RTL and testbench

//  Command decoder plus single-port RAM; sits directly downstream of the SPI slave on the same SCK.

---
 rtl/spi_ram_ctrl.sv | 70 +++++++
 tb/tb_spi_ram_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI command decoder with single-port RAM; read data held on tx_data
// until the next command so the slave can shift it out on MISO.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter bit AUTO_INC  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       err_seq,
   output logic       err_addr
);
   typedef enum logic [1:0] {RD_IDLE, RD_ARMED, RD_BUSY} rd_state_t;
   logic [7:0]           r_mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] r_wr_addr, r_rd_addr;
   logic                 r_wr_armed;
   rd_state_t            r_rd_state;
   logic [1:0]           w_op;
   logic [7:0]           w_pay;
   logic [ADDR_SIZE-1:0] w_addr, w_wr_next;
   logic                 w_in_range, w_wr, w_rd;
   assign w_op       = rx_data[9:8];
   assign w_pay      = rx_data[7:0];
   assign w_addr     = w_pay[ADDR_SIZE-1:0];
   assign w_in_range = {1'b0, w_pay} < 9'(MEM_DEPTH);
   assign w_wr       = rx_valid && w_op == 2'b01 && r_wr_armed;
   assign w_rd       = rx_valid && w_op == 2'b11 && r_rd_state == RD_ARMED;
   assign w_wr_next  = (r_wr_addr == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : r_wr_addr + 1'b1;
   // RAM has no reset so its contents survive rst_n and it maps onto block RAM
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_addr] <= w_pay;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         err_seq    <= 1'b0;
         err_addr   <= 1'b0;
         r_wr_addr  <= '0;
         r_rd_addr  <= '0;
         r_wr_armed <= 1'b0;
         r_rd_state <= RD_IDLE;
      end else begin
         err_seq  <= 1'b0;
         err_addr <= 1'b0;
         if (rx_valid) begin
            tx_valid <= w_rd;
            if (r_rd_state == RD_BUSY) r_rd_state <= RD_IDLE;
            case (w_op)
               2'b00: if (w_in_range) begin
                  r_wr_addr  <= w_addr;
                  r_wr_armed <= 1'b1;
               end else err_addr <= 1'b1;
               2'b01: if (!r_wr_armed) err_seq <= 1'b1;
                  else if (AUTO_INC) r_wr_addr <= w_wr_next;
               2'b10: if (w_in_range) begin
                  r_rd_addr  <= w_addr;
                  r_rd_state <= RD_ARMED;
               end else err_addr <= 1'b1;
               default: if (w_rd) begin
                  tx_data    <= r_mem[r_rd_addr];
                  r_rd_state <= RD_BUSY;
               end else err_seq <= 1'b1;
            endcase
         end
      end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed checks on a 256-word instance and a 16-word auto-increment instance.
module tb_spi_ram_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [9:0] rxd_a = '0, rxd_b = '0;
   logic       rxv_a = 1'b0, rxv_b = 1'b0;
   logic [7:0] txd_a, txd_b;
   logic       txv_a, txv_b, es_a, es_b, ea_a, ea_b;
   int         checks = 0, errors = 0;
   always #5 clk = ~clk;
   spi_ram_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .rx_data(rxd_a), .rx_valid(rxv_a),
      .tx_data(txd_a), .tx_valid(txv_a), .err_seq(es_a), .err_addr(ea_a));
   spi_ram_ctrl #(.MEM_DEPTH(16), .ADDR_SIZE(4), .AUTO_INC(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .rx_data(rxd_b), .rx_valid(rxv_b),
      .tx_data(txd_b), .tx_valid(txv_b), .err_seq(es_b), .err_addr(ea_b));
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send(input bit b, input logic [1:0] op, input logic [7:0] pay);
      @(negedge clk);
      if (b) begin rxd_b = {op, pay}; rxv_b = 1'b1; end
      else   begin rxd_a = {op, pay}; rxv_a = 1'b1; end
      @(posedge clk);
      #1;
      rxv_a = 1'b0;
      rxv_b = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   task automatic pulse_reset;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask
   initial begin
      #1;
      chk("rst_txv", txv_a, 0);
      chk("rst_es", es_a, 0);
      chk("rst_ea", ea_a, 0);
      chk("rst_txd", txd_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // mem[0]=0x77 must survive the next reset and the unarmed write
      send(0, 2'b00, 8'h00);
      send(0, 2'b01, 8'h77);
      pulse_reset();
      send(0, 2'b01, 8'h33);
      chk("unarmed_wr_es", es_a, 1);
      idle(1);
      chk("es_one_cycle", es_a, 0);
      send(0, 2'b11, 8'h00);
      chk("unarmed_rd_es", es_a, 1);
      chk("unarmed_rd_txv", txv_a, 0);
      send(0, 2'b10, 8'h00);
      send(0, 2'b11, 8'h00);
      chk("mem_survives_rst", txd_a, 8'h77);
      send(0, 2'b00, 8'h12);
      chk("wa_clears_txv", txv_a, 0);
      send(0, 2'b01, 8'hA5);
      chk("wd_no_es", es_a, 0);
      send(0, 2'b10, 8'h12);
      chk("ra_no_ea", ea_a, 0);
      send(0, 2'b11, 8'h00);
      chk("rd_txv", txv_a, 1);
      chk("rd_txd", txd_a, 8'hA5);
      chk("rd_no_es", es_a, 0);
      idle(10);
      chk("hold_txv", txv_a, 1);
      chk("hold_txd", txd_a, 8'hA5);
      send(0, 2'b00, 8'h01);
      chk("next_cmd_clr_txv", txv_a, 0);
      send(0, 2'b10, 8'h12);
      send(0, 2'b11, 8'h00);
      chk("rd2_txd", txd_a, 8'hA5);
      send(0, 2'b11, 8'h00);
      chk("double_rd_es", es_a, 1);
      chk("double_rd_txd", txd_a, 8'hA5);
      chk("double_rd_txv", txv_a, 0);
      send(0, 2'b00, 8'h21);
      send(0, 2'b01, 8'h99);
      send(0, 2'b00, 8'h20);
      send(0, 2'b01, 8'h11);
      send(0, 2'b01, 8'h22);
      send(0, 2'b10, 8'h20);
      send(0, 2'b11, 8'h00);
      chk("noinc_same_word", txd_a, 8'h22);
      send(0, 2'b10, 8'h20);
      send(0, 2'b10, 8'h21);
      send(0, 2'b11, 8'h00);
      chk("rearm_no_inc", txd_a, 8'h99);
      chk("rearm_txv", txv_a, 1);
      send(0, 2'b00, 8'hFF);
      chk("ff_in_range", ea_a, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_txv", txv_a, 0);
      chk("async_rst_txd", txd_a, 0);
      #1;
      rst_n = 1'b1;
      send(1, 2'b00, 8'h10);
      chk("b_wa_oob_ea", ea_b, 1);
      idle(1);
      chk("b_ea_one_cycle", ea_b, 0);
      send(1, 2'b01, 8'h55);
      chk("b_not_armed_es", es_b, 1);
      send(1, 2'b10, 8'h10);
      chk("b_ra_oob_ea", ea_b, 1);
      send(1, 2'b10, 8'h0F);
      chk("b_ra_0f_ok", ea_b, 0);
      send(1, 2'b00, 8'h0F);
      chk("b_wa_0f_ok", ea_b, 0);
      send(1, 2'b01, 8'h11);
      send(1, 2'b01, 8'h22);
      chk("b_wd2_no_es", es_b, 0);
      send(1, 2'b10, 8'h0F);
      send(1, 2'b11, 8'h00);
      chk("b_rd_0f", txd_b, 8'h11);
      send(1, 2'b10, 8'h00);
      send(1, 2'b11, 8'h00);
      chk("b_rd_wrap_00", txd_b, 8'h22);
      chk("b_rd_txv", txv_b, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
